// File: rtl/write_iface_pkg.sv
// Shared constants and helpers for the planar VGA CPU-write path.
// Holds write modes, raster ops, FSM encodings and the plane-search/ROP functions.
package write_iface_pkg;

  localparam logic [1:0] WM0 = 2'd0;
  localparam logic [1:0] WM1 = 2'd1;
  localparam logic [1:0] WM2 = 2'd2;
  localparam logic [1:0] WM3 = 2'd3;

  localparam logic [1:0] ROP_COPY = 2'd0;
  localparam logic [1:0] ROP_AND  = 2'd1;
  localparam logic [1:0] ROP_OR   = 2'd2;
  localparam logic [1:0] ROP_XOR  = 2'd3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  function automatic logic [15:0] rop_apply(input logic [1:0] op,
                                            input logic [15:0] s,
                                            input logic [15:0] l);
    logic [15:0] r;
    case (op)
      ROP_COPY: r = s;
      ROP_AND:  r = s & l;
      ROP_OR:   r = s | l;
      ROP_XOR:  r = s ^ l;
      default:  r = s;
    endcase
    return r;
  endfunction

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [2:0] next_plane(input logic [3:0] mask,
                                            input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        res = {1'b1, i[1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/write_iface_alu.sv
// Combinational per-plane write data: set/reset, raster op and bit mask
// applied against the read-side latch of the selected plane.
module write_plane_alu
  import write_iface_pkg::*;
(
  input  logic [1:0]  plane_i,
  input  logic [15:0] dat_i,
  input  logic [7:0]  latch0_i,
  input  logic [7:0]  latch1_i,
  input  logic [7:0]  latch2_i,
  input  logic [7:0]  latch3_i,
  input  logic [1:0]  write_mode_i,
  input  logic [1:0]  raster_op_i,
  input  logic [7:0]  bit_mask_i,
  input  logic [3:0]  set_reset_i,
  input  logic [3:0]  enable_set_reset_i,
  output logic [15:0] dat_o
);

  logic [7:0]  lat_s;
  logic [15:0] l16_s;
  logic [15:0] m16_s;
  logic [15:0] src_s;
  logic [15:0] msk_s;

  // Plane data function for the four VGA write modes.
  always_comb begin
    case (plane_i)
      2'd0:    lat_s = latch0_i;
      2'd1:    lat_s = latch1_i;
      2'd2:    lat_s = latch2_i;
      2'd3:    lat_s = latch3_i;
      default: lat_s = latch0_i;
    endcase
    l16_s = {lat_s, lat_s};
    m16_s = {bit_mask_i, bit_mask_i};
    src_s = 16'h0000;
    msk_s = m16_s;
    case (write_mode_i)
      WM0: begin
        src_s = enable_set_reset_i[plane_i] ? {16{set_reset_i[plane_i]}} : dat_i;
        dat_o = (rop_apply(raster_op_i, src_s, l16_s) & msk_s) | (l16_s & ~msk_s);
      end
      WM1: begin
        dat_o = l16_s;
      end
      WM2: begin
        src_s = {{8{dat_i[{2'b10, plane_i}]}}, {8{dat_i[{2'b00, plane_i}]}}};
        dat_o = (rop_apply(raster_op_i, src_s, l16_s) & msk_s) | (l16_s & ~msk_s);
      end
      WM3: begin
        src_s = {16{set_reset_i[plane_i]}};
        msk_s = m16_s & dat_i;
        dat_o = (rop_apply(raster_op_i, src_s, l16_s) & msk_s) | (l16_s & ~msk_s);
      end
      default: begin
        dat_o = l16_s;
      end
    endcase
  end

endmodule

// File: rtl/write_iface.sv
// CPU write into planar VGA memory: one Wishbone slave write becomes one
// SRAM master write per plane enabled in map_mask, then a single slave ack.
module write_iface
  import write_iface_pkg::*;
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [16:1] wbs_adr_i,
  input  logic [1:0]  wbs_sel_i,
  input  logic [15:0] wbs_dat_i,
  input  logic        wbs_stb_i,
  output logic        wbs_ack_o,
  output logic [17:1] wbm_adr_o,
  output logic [1:0]  wbm_sel_o,
  output logic [15:0] wbm_dat_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        memory_mapping1,
  input  logic [1:0]  write_mode,
  input  logic [1:0]  raster_op,
  input  logic [7:0]  bit_mask,
  input  logic [3:0]  set_reset,
  input  logic [3:0]  enable_set_reset,
  input  logic [3:0]  map_mask,
  input  logic [7:0]  latch0,
  input  logic [7:0]  latch1,
  input  logic [7:0]  latch2,
  input  logic [7:0]  latch3
);

  logic [1:0]  state_q, state_d;
  logic [1:0]  plane_q, plane_d;
  logic [15:1] off_q, off_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] dat_q, dat_d;
  logic        sack_q, sack_d;
  logic        mstb_q, mstb_d;
  logic [2:0]  srch_s;
  logic        adr_unused;

  // The top address bit is not part of the planar offset in either mapping.
  assign adr_unused = wbs_adr_i[16];

  // Next-state: capture, plane walk over enabled planes, and ack pulse.
  always_comb begin
    state_d = state_q;
    plane_d = plane_q;
    off_d   = off_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    sack_d  = 1'b0;
    mstb_d  = 1'b0;
    srch_s  = 3'b000;
    case (state_q)
      IDLE: begin
        if (wbs_stb_i) begin
          off_d  = memory_mapping1 ? {1'b0, wbs_adr_i[14:1]} : wbs_adr_i[15:1];
          sel_d  = wbs_sel_i;
          dat_d  = wbs_dat_i;
          srch_s = next_plane(map_mask, 3'd0);
          if (srch_s[2]) begin
            state_d = WRITE;
            plane_d = srch_s[1:0];
            mstb_d  = 1'b1;
          end else begin
            state_d = ACK;
            sack_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (wbm_ack_i) begin
          srch_s = next_plane(map_mask, {1'b0, plane_q} + 3'd1);
          if (srch_s[2]) begin
            plane_d = srch_s[1:0];
            mstb_d  = 1'b1;
          end else begin
            state_d = ACK;
            sack_d  = 1'b1;
          end
        end else begin
          mstb_d = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers; reset aborts any transaction in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      plane_q <= 2'd0;
      off_q   <= 15'd0;
      sel_q   <= 2'd0;
      dat_q   <= 16'd0;
      sack_q  <= 1'b0;
      mstb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      plane_q <= plane_d;
      off_q   <= off_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      sack_q  <= sack_d;
      mstb_q  <= mstb_d;
    end
  end

  assign wbs_ack_o = sack_q;
  assign wbm_stb_o = mstb_q;
  assign wbm_adr_o = {plane_q, off_q};
  assign wbm_sel_o = sel_q;

  write_plane_alu u_alu (
    .plane_i            (plane_q),
    .dat_i              (dat_q),
    .latch0_i           (latch0),
    .latch1_i           (latch1),
    .latch2_i           (latch2),
    .latch3_i           (latch3),
    .write_mode_i       (write_mode),
    .raster_op_i        (raster_op),
    .bit_mask_i         (bit_mask),
    .set_reset_i        (set_reset),
    .enable_set_reset_i (enable_set_reset),
    .dat_o              (wbm_dat_o)
  );

endmodule

// File: tb/tb_write_iface.sv
// Randomized bench for write_iface against a bit-level reference model,
// with a one-cycle-ack SRAM responder and the directed scenarios up front.
module tb_write_iface;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wbs_adr;
  logic [1:0]  wbs_sel;
  logic [15:0] wbs_dat;
  logic        wbs_stb;
  logic        wbs_ack_o;
  logic [16:0] wbm_adr_o;
  logic [1:0]  wbm_sel_o;
  logic [15:0] wbm_dat_o;
  logic        wbm_stb_o;
  logic        sram_ack;
  logic        mm1;
  logic [1:0]  wmode, rop;
  logic [7:0]  bmask;
  logic [3:0]  sr, esr, mmask;
  logic [7:0]  lat [4];

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [16:0] adr;
    logic [1:0]  sel;
    logic [15:0] dat;
  } wr_t;
  wr_t obs_q[$];

  always #5 clk = ~clk;

  write_iface dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_adr_i(wbs_adr), .wbs_sel_i(wbs_sel), .wbs_dat_i(wbs_dat),
    .wbs_stb_i(wbs_stb), .wbs_ack_o(wbs_ack_o),
    .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
    .wbm_stb_o(wbm_stb_o), .wbm_ack_i(sram_ack),
    .memory_mapping1(mm1), .write_mode(wmode), .raster_op(rop),
    .bit_mask(bmask), .set_reset(sr), .enable_set_reset(esr), .map_mask(mmask),
    .latch0(lat[0]), .latch1(lat[1]), .latch2(lat[2]), .latch3(lat[3])
  );

  // SRAM responder: acks each strobe one cycle after seeing it.
  always @(posedge clk or posedge rst) begin
    if (rst) sram_ack <= 1'b0;
    else     sram_ack <= wbm_stb_o & ~sram_ack;
  end

  // Record each completed SRAM write (stb and ack both high before the edge).
  always @(negedge clk) begin
    if (!rst && wbm_stb_o && sram_ack) obs_q.push_back({wbm_adr_o, wbm_sel_o, wbm_dat_o});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_data(input int p, input logic [15:0] d);
    logic [15:0] res;
    for (int b = 0; b < 16; b++) begin
      logic l, m, s, r;
      l = lat[p][b % 8];
      m = bmask[b % 8];
      s = 1'b0;
      case (wmode)
        2'd0: s = esr[p] ? sr[p] : d[b];
        2'd2: s = (b < 8) ? d[p] : d[8 + p];
        2'd3: begin s = sr[p]; m = m & d[b]; end
        default: s = 1'b0;
      endcase
      case (rop)
        2'd0: r = s;
        2'd1: r = s & l;
        2'd2: r = s | l;
        default: r = s ^ l;
      endcase
      res[b] = (wmode == 2'd1) ? l : (m ? r : l);
    end
    return res;
  endfunction

  function automatic logic [16:0] model_adr(input int p, input logic [15:0] a);
    int off;
    off = mm1 ? (int'(a) % 16384) : (int'(a) % 32768);
    return 17'(p * 32768 + off);
  endfunction

  task automatic set_cfg(input logic [1:0] m, input logic [1:0] op, input logic [7:0] bm,
                         input logic [3:0] s, input logic [3:0] e, input logic [3:0] mk,
                         input logic mp, input logic [31:0] l);
    @(negedge clk);
    wmode = m; rop = op; bmask = bm; sr = s; esr = e; mmask = mk; mm1 = mp;
    lat[0] = l[7:0]; lat[1] = l[15:8]; lat[2] = l[23:16]; lat[3] = l[31:24];
  endtask

  task automatic run_write(input string tag, input logic [15:0] a, input logic [1:0] s,
                           input logic [15:0] d);
    int cyc, n_exp, k;
    obs_q.delete();
    @(negedge clk);
    wbs_adr = a; wbs_sel = s; wbs_dat = d; wbs_stb = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!wbs_ack_o && cyc < 100);
    wbs_stb = 1'b0;
    n_exp = $countones(mmask);
    check_eq({tag, "_latency"}, cyc, 1 + 2 * n_exp);
    @(negedge clk);
    check_eq({tag, "_ack_pulse"}, wbs_ack_o, 1'b0);
    check_eq({tag, "_nwrites"}, obs_q.size(), n_exp);
    k = 0;
    for (int p = 0; p < 4; p++) begin
      if (mmask[p] && k < obs_q.size()) begin
        check_eq({tag, "_adr"}, obs_q[k].adr, model_adr(p, a));
        check_eq({tag, "_sel"}, obs_q[k].sel, s);
        check_eq({tag, "_dat"}, obs_q[k].dat, model_data(p, d));
        k++;
      end
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; wbs_stb = 1'b0; wbs_adr = 16'h0; wbs_sel = 2'b00; wbs_dat = 16'h0;
    wmode = 2'd0; rop = 2'd0; bmask = 8'hFF; sr = 4'h0; esr = 4'h0; mmask = 4'hF; mm1 = 1'b0;
    for (int i = 0; i < 4; i++) lat[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_sack", wbs_ack_o, 1'b0);
    check_eq("rst_mstb", wbm_stb_o, 1'b0);
    check_eq("rst_madr", wbm_adr_o, 17'h0);
    check_eq("rst_msel", wbm_sel_o, 2'b00);
    rst = 1'b0;

    set_cfg(2'd0, 2'd0, 8'hFF, 4'h0, 4'h0, 4'hF, 1'b0, 32'h0);
    run_write("t1", 16'h0010, 2'b11, 16'hA55A);
    if (obs_q.size() == 4) begin
      check_eq("t1_a0", obs_q[0].adr, 17'h00010);
      check_eq("t1_a1", obs_q[1].adr, 17'h08010);
      check_eq("t1_a2", obs_q[2].adr, 17'h10010);
      check_eq("t1_a3", obs_q[3].adr, 17'h18010);
      check_eq("t1_d3", obs_q[3].dat, 16'hA55A);
    end else check_eq("t1_count", obs_q.size(), 4);

    set_cfg(2'd0, 2'd0, 8'h0F, 4'h1, 4'h5, 4'h1, 1'b0, 32'hF0F0F0F0);
    run_write("t2", 16'h1234, 2'b01, 16'h0000);
    if (obs_q.size() == 1) check_eq("t2_p0", obs_q[0].dat, 16'hFFFF);
    else check_eq("t2_count", obs_q.size(), 1);

    set_cfg(2'd0, 2'd3, 8'hFF, 4'h0, 4'h0, 4'hF, 1'b1, 32'hFFFFFFFF);
    run_write("t3", 16'h4321, 2'b10, 16'h0F0F);
    for (int i = 0; i < obs_q.size(); i++) check_eq("t3_dat", obs_q[i].dat, 16'hF0F0);

    set_cfg(2'd0, 2'd0, 8'hFF, 4'h0, 4'h0, 4'hA, 1'b0, 32'h0);
    run_write("t4a", 16'h0100, 2'b11, 16'h5555);
    if (obs_q.size() == 2) begin
      check_eq("t4_pl1", obs_q[0].adr[16:15], 2'd1);
      check_eq("t4_pl3", obs_q[1].adr[16:15], 2'd3);
    end else check_eq("t4_count", obs_q.size(), 2);
    set_cfg(2'd0, 2'd0, 8'hFF, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0);
    run_write("t4b", 16'h0200, 2'b11, 16'h5555);

    set_cfg(2'd2, 2'd0, 8'hFF, 4'h0, 4'h0, 4'hF, 1'b0, 32'h0);
    run_write("t5", 16'h0040, 2'b11, 16'h0105);
    if (obs_q.size() == 4) begin
      check_eq("t5_p0", obs_q[0].dat, 16'hFFFF);
      check_eq("t5_p1", obs_q[1].dat, 16'h0000);
      check_eq("t5_p2", obs_q[2].dat, 16'h00FF);
      check_eq("t5_p3", obs_q[3].dat, 16'h0000);
    end else check_eq("t5_count", obs_q.size(), 4);

    set_cfg(2'd1, 2'd3, 8'h00, 4'h0, 4'h0, 4'hF, 1'b0, 32'h44332211);
    run_write("t6", 16'h0080, 2'b11, 16'hDEAD);
    if (obs_q.size() == 4) begin
      check_eq("t6_p0", obs_q[0].dat, 16'h1111);
      check_eq("t6_p3", obs_q[3].dat, 16'h4444);
    end else check_eq("t6_count", obs_q.size(), 4);

    // Reset while the third plane is waiting for its SRAM ack.
    obs_q.delete();
    @(negedge clk);
    wbs_adr = 16'h0300; wbs_sel = 2'b11; wbs_dat = 16'h0000; wbs_stb = 1'b1;
    n = 0;
    while (!(obs_q.size() >= 2 && wbm_stb_o && wbm_adr_o[16:15] == 2'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_reach_p2", (n < 50), 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_mstb", wbm_stb_o, 1'b0);
    check_eq("rst_mid_sack", wbs_ack_o, 1'b0);
    wbs_stb = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_hold_sack", wbs_ack_o, 1'b0);
    end
    check_eq("rst_nwrites", obs_q.size(), 2);
    rst = 1'b0;
    run_write("t6b", 16'h0301, 2'b01, 16'h0000);

    for (int it = 0; it < 40; it++) begin
      set_cfg(2'($urandom), 2'($urandom), 8'($urandom), 4'($urandom), 4'($urandom),
              4'($urandom), 1'($urandom), $urandom);
      run_write("rnd", 16'($urandom), 2'($urandom), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
